dfr_output_argmax: RTL and testbench
====================================

Name: dfr_output_argmax

Overview:
- Downstream consumer of the matrix multiplier's Z result RAM.
- After the multiplier finishes, scans Z row by row. Each row holds NUM_CLASSES output scores for one sample.
- Finds the index of the maximum score per row and writes that class index into a class result RAM for the host/AXI side.
- Start/busy/done handshake; drives a synchronous-read RAM port.

Parameters:
- ADDR_WIDTH, 32, width of z_addr and class_addr.
- DATA_WIDTH, 32, width of z_data and class_data.
- NUM_ROWS, 5, number of rows (samples) in Z.
- NUM_CLASSES, 5, number of columns (scores) per row; must be >= 1.
- RAM_LATENCY, 1, cycles from z_addr presented to z_data valid; must be >= 1.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, begin scan; sampled only in IDLE.
- z_data, input, DATA_WIDTH, Z RAM read data.
- z_addr, output, ADDR_WIDTH, Z RAM read address (row-major: row*NUM_CLASSES + col).
- class_addr, output, ADDR_WIDTH, class RAM write address (= row index).
- class_data, output, DATA_WIDTH, winning column index, zero-extended.
- class_wen, output, 1, class RAM write enable, one-cycle pulse per row.
- busy, output, 1, high from the cycle after start is accepted until the done cycle.
- done, output, 1, one-cycle pulse when all rows are written.

Behaviour:
- Reset values (rst high, asynchronous): all outputs 0; state IDLE; row counter, column counter, wait counter, best_val and best_idx all 0. Reset mid-scan aborts immediately; no further class_wen is issued.
- States: IDLE, ISSUE, WAIT, CMP, WRITE, DONE.
- IDLE:
  - start=1 → ISSUE; busy=1 from the next cycle.
  - Row and column counters cleared; z_addr=0.
- ISSUE:
  - z_addr = row*NUM_CLASSES + col, held stable until the next ISSUE.
  - Goes to CMP if RAM_LATENCY==1, else to WAIT.
- WAIT: stays RAM_LATENCY-1 cycles, then goes to CMP.
- CMP:
  - z_data is valid this cycle.
  - If col==0, best_val<=z_data and best_idx<=0 unconditionally.
  - Otherwise, if z_data > best_val (strictly), best_val<=z_data and best_idx<=col.
  - Ties keep the lower index.
  - If col==NUM_CLASSES-1 → WRITE; else col++ and → ISSUE.
- WRITE:
  - class_wen=1 for exactly this cycle; class_addr=row; class_data=best_idx (winning column index of the row just scanned).
  - col<=0.
  - If row==NUM_ROWS-1 → DONE; else row++ and → ISSUE.
- DONE:
  - done=1 and busy=0 in this cycle; → IDLE.
  - class_wen=0 everywhere outside WRITE.
- start while busy or in DONE is ignored.
- Timing: each element takes 1+RAM_LATENCY cycles. Each row takes NUM_CLASSES*(1+RAM_LATENCY)+1 cycles. The done pulse comes 1 cycle after the last WRITE.
- Example, defaults: busy rises cycle 1 after start; first WRITE at cycle 11; last WRITE at cycle 55; done at cycle 56.
- Compare width is the full DATA_WIDTH; no truncation. best_idx register width is clog2(NUM_CLASSES), minimum 1 bit.
- z_addr arithmetic is done in ADDR_WIDTH and wraps modulo 2^ADDR_WIDTH (not expected at legal parameter values).

Optional Feature:
- Macro: DFR_ARGMAX_SIGNED_EN.
- Defined: z_data and best_val are compared as two's-complement signed. Example: 0xFFFFFFFF (-1) loses to 0x00000001.
- Undefined: unsigned compare. Example: 0xFFFFFFFF wins over 0x00000001.
- All other behaviour and timing are identical.

Test Plan:
- Defaults, Z row r = {0,0,r+10,0,0} → class RAM[0..4] all = 2; exactly 5 class_wen pulses at cycles 11,22,33,44,55; done at cycle 56; busy high cycles 1-55.
- Tie: row 0 = {7,3,7,7,1} → class RAM[0]=0; row 1 = {1,2,9,9,9} → class RAM[1]=2.
- Max in the last column: row = {1,2,3,4,100} → class 4. Max in column 0: row = {100,1,2,3,4} → class 0.
- Signed feature: row = {0xFFFFFFFF,1,0,0,0} → class 1 with DFR_ARGMAX_SIGNED_EN defined, class 0 without.
- Reset mid-scan: assert rst at cycle 20 → all outputs 0 the same cycle; no class_wen afterwards. A new start after release completes a full scan with done at cycle 56.
- start held high through the scan, and RAM_LATENCY=3 → a single scan only; each element takes 4 cycles; first WRITE at cycle 21; done pulses once, and busy falls in the done cycle.

Source files
------------

// File: rtl/dfr_output_argmax.sv
// Scans the Z result RAM row by row and writes the argmax column of each row to the class RAM.
// Define DFR_ARGMAX_SIGNED_EN to compare scores as two's-complement signed instead of unsigned.
module dfr_output_argmax #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ROWS    = 5,
  parameter int NUM_CLASSES = 5,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] z_data,
  output logic [ADDR_WIDTH-1:0] z_addr,
  output logic [ADDR_WIDTH-1:0] class_addr,
  output logic [DATA_WIDTH-1:0] class_data,
  output logic                  class_wen,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int WAIT_W = (RAM_LATENCY > 2) ? $clog2(RAM_LATENCY - 1) : 1;

  localparam logic [IDX_W-1:0]  LAST_COL  = IDX_W'(NUM_CLASSES - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_ROWS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'((RAM_LATENCY > 1) ? (RAM_LATENCY - 2) : 0);
  localparam logic              SINGLE_LAT = (RAM_LATENCY == 1) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CMP   = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                state_r,      state_s;
  logic [ROW_W-1:0]      row_r,        row_s;
  logic [IDX_W-1:0]      col_r,        col_s;
  logic [WAIT_W-1:0]     wait_r,       wait_s;
  logic [DATA_WIDTH-1:0] best_val_r,   best_val_s;
  logic [IDX_W-1:0]      best_idx_r,   best_idx_s;
  logic [ADDR_WIDTH-1:0] z_addr_r,     z_addr_s;
  logic [ADDR_WIDTH-1:0] class_addr_r, class_addr_s;
  logic [DATA_WIDTH-1:0] class_data_r, class_data_s;
  logic                  class_wen_r,  class_wen_s;
  logic                  busy_r,       busy_s;
  logic                  done_r,       done_s;

  // Strict "greater than" so that ties keep the earlier (lower) column.
  function automatic logic score_gt(input logic [DATA_WIDTH-1:0] a,
                                    input logic [DATA_WIDTH-1:0] b);
`ifdef DFR_ARGMAX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_s      = state_r;
    row_s        = row_r;
    col_s        = col_r;
    wait_s       = wait_r;
    best_val_s   = best_val_r;
    best_idx_s   = best_idx_r;
    z_addr_s     = z_addr_r;
    class_addr_s = {ADDR_WIDTH{1'b0}};
    class_data_s = {DATA_WIDTH{1'b0}};
    class_wen_s  = 1'b0;
    busy_s       = 1'b0;
    done_s       = 1'b0;

    case (state_r)
      S_IDLE: begin
        row_s = {ROW_W{1'b0}};
        col_s = {IDX_W{1'b0}};
        if (start) begin
          state_s = S_ISSUE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        wait_s = {WAIT_W{1'b0}};
        if (SINGLE_LAT) begin
          state_s = S_CMP;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_r == LAST_WAIT) begin
          state_s = S_CMP;
        end else begin
          wait_s = wait_r + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      S_CMP: begin
        if (col_r == {IDX_W{1'b0}}) begin
          best_val_s = z_data;
          best_idx_s = {IDX_W{1'b0}};
        end else if (score_gt(z_data, best_val_r)) begin
          best_val_s = z_data;
          best_idx_s = col_r;
        end else begin
          best_val_s = best_val_r;
        end
        if (col_r == LAST_COL) begin
          state_s = S_WRITE;
        end else begin
          col_s   = col_r + {{(IDX_W-1){1'b0}}, 1'b1};
          state_s = S_ISSUE;
        end
      end
      S_WRITE: begin
        col_s = {IDX_W{1'b0}};
        if (row_r == LAST_ROW) begin
          state_s = S_DONE;
        end else begin
          row_s   = row_r + {{(ROW_W-1){1'b0}}, 1'b1};
          state_s = S_ISSUE;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (state_s)
      S_IDLE: begin
        z_addr_s = {ADDR_WIDTH{1'b0}};
      end
      S_ISSUE: begin
        busy_s   = 1'b1;
        z_addr_s = ADDR_WIDTH'(row_s) * ADDR_WIDTH'(NUM_CLASSES) + ADDR_WIDTH'(col_s);
      end
      S_WAIT, S_CMP: begin
        busy_s = 1'b1;
      end
      S_WRITE: begin
        busy_s       = 1'b1;
        class_wen_s  = 1'b1;
        class_addr_s = {{(ADDR_WIDTH-ROW_W){1'b0}}, row_r};
        class_data_s = {{(DATA_WIDTH-IDX_W){1'b0}}, best_idx_s};
      end
      S_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // State, counters, running maximum and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      row_r        <= {ROW_W{1'b0}};
      col_r        <= {IDX_W{1'b0}};
      wait_r       <= {WAIT_W{1'b0}};
      best_val_r   <= {DATA_WIDTH{1'b0}};
      best_idx_r   <= {IDX_W{1'b0}};
      z_addr_r     <= {ADDR_WIDTH{1'b0}};
      class_addr_r <= {ADDR_WIDTH{1'b0}};
      class_data_r <= {DATA_WIDTH{1'b0}};
      class_wen_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      row_r        <= row_s;
      col_r        <= col_s;
      wait_r       <= wait_s;
      best_val_r   <= best_val_s;
      best_idx_r   <= best_idx_s;
      z_addr_r     <= z_addr_s;
      class_addr_r <= class_addr_s;
      class_data_r <= class_data_s;
      class_wen_r  <= class_wen_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  assign z_addr     = z_addr_r;
  assign class_addr = class_addr_r;
  assign class_data = class_data_r;
  assign class_wen  = class_wen_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_dfr_output_argmax.sv
// Bench for dfr_output_argmax: two instances (RAM latency 1 and 3) checked against a timing/argmax model.
module tb_dfr_output_argmax;

  localparam int NR = 5;
  localparam int NC = 5;
  localparam int DW = 32;
  localparam int AW = 32;
`ifdef DFR_ARGMAX_SIGNED_EN
  localparam int SGN_CLS = 1;
`else
  localparam int SGN_CLS = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start1, start3;
  logic [DW-1:0] z_data1, z_data3, class_data1, class_data3;
  logic [AW-1:0] z_addr1, z_addr3, class_addr1, class_addr3;
  logic          class_wen1, class_wen3, busy1, busy3, done1, done3;

  dfr_output_argmax #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ROWS(NR), .NUM_CLASSES(NC), .RAM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .z_data(z_data1), .z_addr(z_addr1),
    .class_addr(class_addr1), .class_data(class_data1), .class_wen(class_wen1),
    .busy(busy1), .done(done1));

  dfr_output_argmax #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ROWS(NR), .NUM_CLASSES(NC), .RAM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .z_data(z_data3), .z_addr(z_addr3),
    .class_addr(class_addr3), .class_data(class_data3), .class_wen(class_wen3),
    .busy(busy3), .done(done3));

  // Z RAM with per-instance read pipelines
  logic [DW-1:0] mem [0:NR*NC-1];
  logic [DW-1:0] p1;
  logic [DW-1:0] p3 [0:2];

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (a < 32'd25) return mem[a[4:0]];
    return '0;
  endfunction

  always @(posedge clk) begin
    p1    <= mem_rd(z_addr1);
    p3[0] <= mem_rd(z_addr3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign z_data1 = p1;
  assign z_data3 = p3[2];

  // Class RAM capture
  logic [DW-1:0] cram [0:NR-1];
  int            wcount = 0;
  logic          cram_clr = 1'b1;

  always @(posedge clk) begin
    if (cram_clr) begin
      for (int i = 0; i < NR; i++) cram[i] <= '1;
      wcount <= 0;
    end else if (class_wen1) begin
      cram[class_addr1[2:0]] <= class_data1;
      wcount <= wcount + 1;
    end else if (class_wen3) begin
      cram[class_addr3[2:0]] <= class_data3;
      wcount <= wcount + 1;
    end
  end

  int gcyc = 0;
  always @(posedge clk) gcyc <= gcyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: first maximum of each row under the active compare rule
  function automatic logic gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef DFR_ARGMAX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  function automatic int argmax_row(input int r);
    int best = 0;
    for (int j = 1; j < NC; j++)
      if (gt(mem[r*NC+j], mem[r*NC+best])) best = j;
    return best;
  endfunction

  int model_cls [0:NR-1];

  task automatic build_model();
    for (int r = 0; r < NR; r++) model_cls[r] = argmax_row(r);
  endtask

  task automatic load_a();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        mem[r*NC+c] = (c == 2) ? DW'(r + 10) : '0;
    build_model();
  endtask

  task automatic load_b();
    logic [DW-1:0] v [0:NR*NC-1];
    v = '{32'd7, 32'd3, 32'd7, 32'd7, 32'd1,
          32'd1, 32'd2, 32'd9, 32'd9, 32'd9,
          32'd1, 32'd2, 32'd3, 32'd4, 32'd100,
          32'd100, 32'd1, 32'd2, 32'd3, 32'd4,
          32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < NR*NC; i++) mem[i] = v[i];
    build_model();
  endtask

  // Compare process: expected outputs derived from the cycle offset since start
  logic mon_active = 1'b0;
  int   sel = 0;
  int   t0 = 0;
  int   m_rel, m_lat, m_r, m_last, m_row, m_q;
  logic e_busy, e_done, e_wen;
  logic a_busy, a_done, a_wen;
  logic [AW-1:0] a_zaddr, a_caddr;
  logic [DW-1:0] a_cdata;

  always @(negedge clk) begin
    if (mon_active) begin
      m_rel   = gcyc - t0;
      m_lat   = (sel != 0) ? 3 : 1;
      m_r     = NC * (1 + m_lat) + 1;
      m_last  = NR * m_r;
      a_busy  = (sel != 0) ? busy3 : busy1;
      a_done  = (sel != 0) ? done3 : done1;
      a_wen   = (sel != 0) ? class_wen3 : class_wen1;
      a_zaddr = (sel != 0) ? z_addr3 : z_addr1;
      a_caddr = (sel != 0) ? class_addr3 : class_addr1;
      a_cdata = (sel != 0) ? class_data3 : class_data1;
      e_busy  = (m_rel >= 1) && (m_rel <= m_last);
      e_done  = (m_rel == m_last + 1);
      e_wen   = e_busy && ((m_rel % m_r) == 0);
      check("busy", 64'(a_busy), 64'(e_busy));
      check("done", 64'(a_done), 64'(e_done));
      check("class_wen", 64'(a_wen), 64'(e_wen));
      if (e_wen) begin
        m_row = m_rel / m_r - 1;
        check("class_addr", 64'(a_caddr), 64'(m_row));
        check("class_data", 64'(a_cdata), 64'(model_cls[m_row]));
      end
      if (e_busy) begin
        m_row = (m_rel - 1) / m_r;
        m_q   = (m_rel - 1) % m_r;
        if (m_q < NC * (1 + m_lat))
          check("z_addr", 64'(a_zaddr), 64'(m_row * NC + m_q / (1 + m_lat)));
      end
    end
  end

  task automatic clear_cram();
    @(posedge clk); #1;
    cram_clr = 1'b1;
    @(posedge clk); #1;
    cram_clr = 1'b0;
  endtask

  task automatic run_scan(input int s, input bit hold);
    int last;
    last = NR * (NC * (1 + ((s != 0) ? 3 : 1)) + 1);
    clear_cram();
    sel = s; t0 = gcyc; mon_active = 1'b1;
    if (s != 0) start3 = 1'b1; else start1 = 1'b1;
    for (int k = 1; k <= last + 4; k++) begin
      @(posedge clk); #1;
      if ((k == 1 && !hold) || k == last + 2) begin
        start1 = 1'b0;
        start3 = 1'b0;
      end
    end
    mon_active = 1'b0;
  endtask

  task automatic check_cram(input string nm, input int c0, input int c1, input int c2,
                            input int c3, input int c4);
    check({nm, "_ram0"}, 64'(cram[0]), 64'(c0));
    check({nm, "_ram1"}, 64'(cram[1]), 64'(c1));
    check({nm, "_ram2"}, 64'(cram[2]), 64'(c2));
    check({nm, "_ram3"}, 64'(cram[3]), 64'(c3));
    check({nm, "_ram4"}, 64'(cram[4]), 64'(c4));
    check({nm, "_writes"}, 64'(wcount), 64'(NR));
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
    load_a();
    repeat (3) @(posedge clk); #1;
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_done", 64'(done1), 64'd0);
    check("rst_wen", 64'(class_wen1), 64'd0);
    check("rst_zaddr", 64'(z_addr1), 64'd0);
    check("rst_caddr", 64'(class_addr1), 64'd0);
    check("rst_cdata", 64'(class_data1), 64'd0);
    check("rst_busy3", 64'(busy3), 64'd0);
    rst = 1'b0;

    // Pin the model against hand-computed classes
    check("model_a_row0", 64'(model_cls[0]), 64'd2);
    check("model_a_row4", 64'(model_cls[4]), 64'd2);
    load_b();
    check("model_b_tie0", 64'(model_cls[0]), 64'd0);
    check("model_b_tie1", 64'(model_cls[1]), 64'd2);
    check("model_b_last", 64'(model_cls[2]), 64'd4);
    check("model_b_first", 64'(model_cls[3]), 64'd0);
    check("model_b_sign", 64'(model_cls[4]), 64'(SGN_CLS));

    load_a();
    run_scan(0, 1'b0);
    check_cram("scan_a", 2, 2, 2, 2, 2);

    load_b();
    run_scan(0, 1'b0);
    check_cram("scan_b", 0, 2, 4, 0, SGN_CLS);

    // Reset in the middle of a scan
    clear_cram();
    sel = 0; t0 = gcyc; mon_active = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (19) @(posedge clk); #1;
    mon_active = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy1), 64'd0);
    check("midrst_wen", 64'(class_wen1), 64'd0);
    check("midrst_zaddr", 64'(z_addr1), 64'd0);
    check("midrst_cdata", 64'(class_data1), 64'd0);
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("postrst_wen", 64'(class_wen1), 64'd0);
      check("postrst_busy", 64'(busy1), 64'd0);
    end
    check("midrst_writes", 64'(wcount), 64'd1);

    run_scan(0, 1'b0);
    check_cram("rescan", 0, 2, 4, 0, SGN_CLS);

    // Latency 3 with start held high through the whole scan
    run_scan(1, 1'b1);
    check_cram("lat3", 0, 2, 4, 0, SGN_CLS);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
